mem_align_unit: RTL

MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

---
 rtl/mem_align_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - byte/half/word/dword load-store aligner for a single-port word SRAM
// Optional MEM_ALIGN_SPLIT_EN: misaligned accesses crossing a word become two beats instead of errors.
module mem_align_unit #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 14,
  localparam int NB     = DATA_W / 8,
  localparam int LB     = $clog2(NB)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W+LB-1:0] req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 mem_cs,
  output logic [NB-1:0]        mem_web,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err
);

`ifdef MEM_ALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [LB+1:0] NB_W = (LB+2)'(NB);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, uns_q, err_q, split_q;
  logic [1:0]            size_q;
  logic [ADDR_W+LB-1:0]  addr_q;
  logic [DATA_W-1:0]     wdata_q, cap_q;

  logic [LB+1:0]         in_bytes, in_end;
  logic                  in_split, in_bad;

  logic [LB-1:0]         off_q;
  logic [ADDR_W-1:0]     word_q;
  logic [LB+1:0]         bytes_q, end_q;

  logic [DATA_W-1:0]     beat0, field, mask, ld_res;
  logic                  sb;

  // Request classification happens at acceptance so the FSM can skip memory on errors.
  assign in_bytes = (LB+2)'(1) << req_size;
  assign in_end   = (LB+2)'(req_addr[LB-1:0]) + in_bytes;
  assign in_split = in_end > NB_W;
  assign in_bad   = (DATA_W == 32) && (req_size == 2'b11);

  assign off_q   = addr_q[LB-1:0];
  assign word_q  = addr_q[ADDR_W+LB-1:LB];
  assign bytes_q = (LB+2)'(1) << size_q;
  assign end_q   = (LB+2)'(off_q) + bytes_q;

  assign req_ready = (state_q == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        split_q <= in_split;
        err_q   <= in_bad || (in_split && !SPLIT_EN);
      end
      if (state_q == ACC1)
        cap_q <= mem_rdata;
    end
  end

  // Beat 0 arrives in RESP for aligned accesses, and was captured in ACC1 for split ones.
  always_comb begin
    beat0  = split_q ? cap_q : mem_rdata;
    field  = DATA_W'({mem_rdata, beat0} >> {off_q, 3'b000});
    mask   = (bytes_q == NB_W) ? '1 : ((DATA_W'(1) << {bytes_q, 3'b000}) - DATA_W'(1));
    case (size_q)
      2'b00:   sb = field[7];
      2'b01:   sb = field[15];
      2'b10:   sb = field[31];
      default: sb = field[DATA_W-1];
    endcase
    ld_res = (field & mask) | ((sb && !uns_q) ? ~mask : '0);
  end

  always_comb begin
    state_d   = state_q;
    mem_cs    = 1'b0;
    mem_web   = '1;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (state_q)
      IDLE: begin
        if (req_valid)
          state_d = (in_bad || (in_split && !SPLIT_EN)) ? RESP : ACC0;
      end
      ACC0: begin
        mem_cs   = 1'b1;
        mem_addr = word_q;
        if (we_q) begin
          mem_wdata = wdata_q << {off_q, 3'b000};
          for (int i = 0; i < NB; i++)
            if (i >= int'(off_q) && i < int'(end_q))
              mem_web[i] = 1'b0;
        end
        state_d = split_q ? ACC1 : RESP;
      end
      ACC1: begin
        mem_cs   = 1'b1;
        mem_addr = word_q + ADDR_W'(1);
        if (we_q) begin
          mem_wdata = wdata_q >> (DATA_W - 8 * int'(off_q));
          for (int i = 0; i < NB; i++)
            if (i < int'(end_q) - NB)
              mem_web[i] = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!we_q && !err_q)
          rsp_rdata = ld_res;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
